// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: the supported requester
// range and the index-width helper. Widths themselves come from the
// module parameters of each user.
package mem_port_arbiter_pkg;

  localparam int MIN_NUM_REQ = 2;
  localparam int MAX_NUM_REQ = 4;

  // Bits needed to hold a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin selector: picks the first requesting index at or above the
// priority pointer, wrapping past the top index back to zero. Purely
// combinational; returns a one-hot grant, the winner index and an
// any-request flag.
module rr_select #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Scan from ptr upward, wrapping, and take the first active request.
  always_comb begin
    int   k;
    logic found;
    gnt   = '0;
    idx   = '0;
    any   = |req;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter placing several requesters onto one single-port SRAM
// with one-cycle read latency. Grants are combinational; the response
// (rvalid) for the granted requester follows one cycle later and read data
// is passed straight through from the SRAM.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_i,
  input  logic [NUM_REQ-1:0]               we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  strb_i,
  output logic [NUM_REQ-1:0]               gnt_o,
  output logic [NUM_REQ-1:0]               rvalid_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic                             mem_req_o,
  output logic                             mem_we_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]          mem_be_o,
  input  logic [DATA_WIDTH-1:0]            mem_rdata_i
);

  localparam int IDX_W  = idx_width(NUM_REQ);
  localparam int STRB_W = DATA_WIDTH / 8;

  if (NUM_REQ < MIN_NUM_REQ || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
    $error("mem_port_arbiter: NUM_REQ must be in 2..4");
  end

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   nxt_ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] sel_gnt;
  logic               any_req;
  logic               grant;

  logic               rsp_vld_p1;
  logic [IDX_W-1:0]   rsp_idx_p1;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req (req_i),
    .ptr (ptr),
    .gnt (sel_gnt),
    .idx (win_idx),
    .any (any_req)
  );

  // Reset masks every grant so nothing reaches the SRAM or the response path.
  assign grant     = any_req & ~rst;
  assign gnt_o     = grant ? sel_gnt : '0;
  assign mem_req_o = grant;
  assign rdata_o   = mem_rdata_i;
  assign nxt_ptr   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

  // Route the winner's command onto the SRAM port; all zero when idle.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_o[i]) begin
        mem_we_o    = we_i[i];
        mem_addr_o  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata_o = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        mem_be_o    = strb_i[i*STRB_W +: STRB_W];
      end
    end
  end

  // Priority pointer moves just past the winner on every granted cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else if (grant) ptr <= nxt_ptr;
  end

  // ---- stage p1: response valid, matching the SRAM read latency ----
  // Valid flag for the response; cleared asynchronously so an in-flight
  // response is dropped the moment reset asserts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rsp_vld_p1 <= 1'b0;
    else     rsp_vld_p1 <= grant;
  end

  // Winner index travelling alongside the valid flag.
  always_ff @(posedge clk) begin
    if (grant) rsp_idx_p1 <= win_idx;
  end

  // Decode the registered winner into its per-requester response strobe.
  always_comb begin
    rvalid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rvalid_o[i] = rsp_vld_p1 & ~rst & (rsp_idx_p1 == IDX_W'(i));
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a driver issues directed and
// random traffic and pushes the expected bus/grant and response for each
// cycle; a monitor compares them against the DUT. A small SRAM model
// with one-cycle read latency sits on the memory port.
module tb_mem_port_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    int          cyc;
    logic [1:0]  gnt;
    logic        mreq;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  typedef struct {
    int          cyc;
    int          idx;
    bit          rd;
    logic [31:0] data;
  } rsp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_i, we_i;
  logic [NR*AW-1:0] addr_i;
  logic [NR*DW-1:0] wdata_i;
  logic [NR*DW/8-1:0] strb_i;
  logic [NR-1:0]  gnt_o, rvalid_o;
  logic [DW-1:0]  rdata_o;
  logic           mem_req_o, mem_we_o;
  logic [AW-1:0]  mem_addr_o;
  logic [DW-1:0]  mem_wdata_o;
  logic [DW/8-1:0] mem_be_o;
  logic [DW-1:0]  mem_rdata_i = '0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int mptr   = 0;

  bus_t bus_q[$];
  rsp_t rsp_q[$];
  logic [31:0] sram    [int unsigned];
  logic [31:0] ref_mem [int unsigned];

  mem_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .strb_i(strb_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Cycle counter shared by driver and monitor for expected-cycle tags.
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: byte-strobed write, one-cycle registered read.
  always @(posedge clk) begin
    if (mem_req_o) begin
      logic [31:0] w;
      w = sram.exists(mem_addr_o[31:2]) ? sram[mem_addr_o[31:2]] : 32'h0;
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) if (mem_be_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
        sram[mem_addr_o[31:2]] = w;
      end else begin
        mem_rdata_i <= w;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and record what the arbiter should do with it.
  task automatic drive(input logic r, input logic [1:0] rq, input logic [1:0] we,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] s0, input logic [3:0] s1);
    bus_t e;
    rsp_t rs;
    logic [31:0] a[2];
    logic [31:0] d[2];
    logic [3:0]  s[2];
    logic [31:0] m;
    int win;
    @(posedge clk);
    #1;
    rst = r; req_i = rq; we_i = we;
    addr_i = {a1, a0}; wdata_i = {d1, d0}; strb_i = {s1, s0};
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1; s[0] = s0; s[1] = s1;
    e = '{cyc: cyc, gnt: 2'b00, mreq: 1'b0, we: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'h0};
    if (r) begin
      rsp_q.delete();
      mptr = 0;
    end else if (rq != 2'b00) begin
      win = -1;
      for (int k = 0; k < NR; k++) begin
        if (win < 0 && rq[(mptr + k) % NR]) win = (mptr + k) % NR;
      end
      e.gnt = 2'(1 << win); e.mreq = 1'b1; e.we = we[win];
      e.addr = a[win]; e.wdata = d[win]; e.be = s[win];
      m = ref_mem.exists(a[win][31:2]) ? ref_mem[a[win][31:2]] : 32'h0;
      if (we[win]) begin
        for (int b = 0; b < 4; b++) if (s[win][b]) m[8*b +: 8] = d[win][8*b +: 8];
        ref_mem[a[win][31:2]] = m;
      end
      rs = '{cyc: cyc + 1, idx: win, rd: !we[win], data: m};
      rsp_q.push_back(rs);
      mptr = (win + 1) % NR;
    end
    bus_q.push_back(e);
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    sram[addr[31:2]]    = val;
    ref_mem[addr[31:2]] = val;
  endtask

  // Monitor: mid-cycle compare of grant/bus and of any due response.
  always @(negedge clk) begin
    bus_t e;
    rsp_t r;
    if (bus_q.size() > 0 && bus_q[0].cyc == cyc) begin
      e = bus_q.pop_front();
      check("gnt_o", 32'(gnt_o), 32'(e.gnt));
      check("mem_req_o", 32'(mem_req_o), 32'(e.mreq));
      check("mem_we_o", 32'(mem_we_o), 32'(e.we));
      check("mem_addr_o", mem_addr_o, e.addr);
      check("mem_wdata_o", mem_wdata_o, e.wdata);
      check("mem_be_o", 32'(mem_be_o), 32'(e.be));
    end
    if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
      r = rsp_q.pop_front();
      check("rvalid_o", 32'(rvalid_o), 32'(1 << r.idx));
      if (r.rd) check("rdata_o", rdata_o, r.data);
    end else if (cyc > 0) begin
      check("rvalid_o_idle", 32'(rvalid_o), 32'h0);
    end
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; strb_i = '0;

    // Reset held with both requesters active.
    repeat (3) drive(1, 2'b11, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0, 4'h0, 4'h0);

    // Contention right after release: alternating grants from index 0.
    for (int i = 0; i < 6; i++)
      drive(0, 2'b11, 2'b00, 32'(i*8), 32'(i*8+4), 32'h0, 32'h0, 4'h0, 4'h0);
    drive(0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);

    // Single read by requester 1.
    preload(32'h10, 32'hDEADBEEF);
    drive(0, 2'b10, 2'b00, 32'h0, 32'h10, 32'h0, 32'h0, 4'h0, 4'h0);
    drive(0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);

    // Partial write by requester 0, read back by requester 1 next cycle.
    preload(32'h20, 32'h12345678);
    drive(0, 2'b01, 2'b01, 32'h20, 32'h0, 32'hA5A5A5A5, 32'h0, 4'b0011, 4'h0);
    drive(0, 2'b10, 2'b00, 32'h0, 32'h20, 32'h0, 32'h0, 4'h0, 4'h0);
    drive(0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);

    // Reset asserted the cycle after a grant; arbitration restarts at 0.
    drive(0, 2'b11, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0, 4'h0, 4'h0);
    drive(1, 2'b11, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0, 4'h0, 4'h0);
    drive(1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    drive(0, 2'b11, 2'b00, 32'h8, 32'hC, 32'h0, 32'h0, 4'h0, 4'h0);
    drive(0, 2'b11, 2'b00, 32'h8, 32'hC, 32'h0, 32'h0, 4'h0, 4'h0);

    // Requester 1 streaming alone.
    for (int i = 0; i < 8; i++)
      drive(0, 2'b10, 2'b00, 32'h0, {26'h0, 4'(i), 2'b00}, 32'h0, 32'h0, 4'h0, 4'h0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 49) == 0), 2'($urandom), 2'($urandom),
            {26'h0, 4'($urandom), 2'b00}, {26'h0, 4'($urandom), 2'b00},
            $urandom, $urandom, 4'($urandom), 4'($urandom));
    end

    repeat (3) drive(0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    @(negedge clk);
    #1;
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
    check("bus_queue_drained", 32'(bus_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, meaning number of requester ports (2..4).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning word width; strobe width is DATA_WIDTH/8.
REQ-004 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports req_i/we_i  input  NUM_REQ each  per-requester request and write-enable.
REQ-007 SHALL have ports addr_i/wdata_i/strb_i  input  NUM_REQ x ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  per-requester address, write data, byte strobes.
REQ-008 SHALL have ports gnt_o/rvalid_o  output  NUM_REQ each  per-requester grant and response valid.
REQ-009 SHALL have port rdata_o  output  DATA_WIDTH  read data, shared by all requesters, qualified by rvalid_o.
REQ-010 SHALL have ports mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_be_o  output  1/1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  single SRAM port.
REQ-011 SHALL have port mem_rdata_i  input  DATA_WIDTH  SRAM read data, valid one cycle after mem_req_o.

Function
REQ-012 SHALL issue at most one memory request per cycle; mem_req_o = OR of req_i when not in reset.
REQ-013 SHALL grant combinationally in the same cycle: exactly one gnt_o bit high, belonging to the round-robin winner, whenever any req_i is high.
REQ-014 SHALL select the winner as the first requesting index at or above priority pointer ptr, wrapping from NUM_REQ-1 to 0.
REQ-015 SHALL update ptr to (winner+1) mod NUM_REQ on every granted cycle; ptr holds when no request is present.
REQ-016 SHALL drive mem_we_o/addr/wdata/be from the winner's inputs in the grant cycle; these are don't-care but stable at zero when idle.
REQ-017 SHALL register the winner index and a valid flag; next cycle assert rvalid_o for that index only, for both reads and writes.
REQ-018 SHALL pass mem_rdata_i to rdata_o unregistered; rdata_o is meaningful only with a read rvalid.
REQ-019 SHALL sustain back-to-back grants: a grant in cycle N and N+1 yields rvalid in N+1 and N+2 with no bubble.
REQ-020 SHALL, with a single requester continuously asserting, grant it every cycle (no starvation-induced bubbles).
REQ-021 SHALL, with all requesters continuously asserting, grant each exactly once per NUM_REQ cycles.
REQ-022 SHALL treat requester behaviour as protocol-compliant: req_i may drop without a grant; the arbiter keeps no per-requester state besides ptr.

Reset
REQ-023 SHALL, while rst is high, force gnt_o, rvalid_o, mem_req_o, mem_we_o to 0 and hold ptr at 0.
REQ-024 SHALL discard any in-flight response on reset assertion; no rvalid_o is produced for a request granted in the cycle reset asserts.
REQ-025 SHALL accept requests the first rising edge after rst deasserts, starting arbitration at index 0.

Structure
REQ-026 SHALL place the round-robin select function (request vector, ptr -> one-hot grant, index) in a sub-module named rr_select, purely combinational.
REQ-027 SHALL keep no shared-package typedefs; all widths derive from module parameters; NUM_REQ range is checked by an elaboration assertion.
REQ-028 SHALL connect between axi_to_mem-style requesters and a single-port tc_sram with one-cycle read latency without glue logic.

Verification
REQ-029 SHALL cover reset: rst high with req_i=2'b11 -> gnt_o=0, mem_req_o=0, rvalid_o=0; after release first grant goes to index 0.
REQ-030 SHALL cover contention: req_i=2'b11 for 6 cycles -> gnt_o sequence 01,10,01,10,01,10; rvalid_o same sequence delayed one cycle.
REQ-031 SHALL cover read data: requester 1 reads addr 0x10 holding 0xDEADBEEF -> gnt_o[1] cycle N, rvalid_o[1] and rdata_o=0xDEADBEEF cycle N+1.
REQ-032 SHALL cover write-then-read: requester 0 writes 0xA5A5A5A5 strb 4'b0011 to 0x20, requester 1 reads 0x20 next cycle -> low halfword 0xA5A5 observed, two rvalids in consecutive cycles.
REQ-033 SHALL cover reset mid-operation: rst asserted the cycle after a grant -> no rvalid_o for that grant; ptr=0 after release.
REQ-034 SHALL cover single requester streaming: req_i[1] high 8 cycles -> 8 consecutive gnt_o[1], 8 rvalid_o[1], mem_req_o never low.
